// File: rtl/ram_pkg.sv
// Encodings shared between the CPU-side access controller and the ram512x8 memory.
package ram_pkg;

  typedef enum logic [1:0] {
    MAS_BYTE    = 2'b00,
    MAS_HALF    = 2'b01,
    MAS_WORD    = 2'b10,
    MAS_ILLEGAL = 2'b11
  } mas_e;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETUP  = 2'b01,
    ST_ACCESS = 2'b10,
    ST_RESP   = 2'b11
  } state_e;

  localparam int unsigned TIMEOUT_DEFAULT = 16;

  // Natural alignment for the access size; MAS=11 is never legal.
  function automatic logic mas_aligned(input logic [1:0] size, input logic [1:0] a);
    logic ok;
    ok = 1'b0;
    case (mas_e'(size))
      MAS_BYTE: ok = 1'b1;
      MAS_HALF: ok = ~a[0];
      MAS_WORD: ok = (a == 2'b00);
      default:  ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/ram_access_ctrl_extend.sv
// Load data extension: zero- or sign-extends right-justified byte/half RAM read data.
module ram_load_extend
  import ram_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_signed,
  input  logic [31:0] d,
  output logic [31:0] extended
);

  always_comb begin
    extended = d;
    case (mas_e'(size))
      MAS_BYTE: extended = is_signed ? {{24{d[7]}}, d[7:0]} : {24'b0, d[7:0]};
      MAS_HALF: extended = is_signed ? {{16{d[15]}}, d[15:0]} : {16'b0, d[15:0]};
      default:  extended = d;
    endcase
  end

endmodule

// File: rtl/ram_access_ctrl.sv
// CPU-side initiator for ram512x8: one load/store at a time, alignment check,
// registered RAM interface, done timeout and load extension.
module ram_access_ctrl
  import ram_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
  parameter int unsigned AW      = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [1:0]    req_size,
  input  logic          req_signed,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          resp_valid,
  output logic          resp_err,
  output logic [31:0]   resp_rdata,
  output logic          ram_enable,
  output logic          ram_rw,
  output logic [AW-1:0] ram_address,
  output logic [1:0]    ram_mas,
  output logic [1:0]    ram_a,
  output logic [31:0]   ram_wdata,
  input  logic [31:0]   ram_rdata,
  input  logic          ram_done
);

  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_e        state;
  state_e        next;
  logic [CW-1:0] cnt;
  logic          write_q;
  logic          signed_q;
  logic          req_legal;
  logic          done_seen;
  logic          at_limit;
  logic [31:0]   load_data;

  assign req_legal = mas_aligned(req_size, req_addr[1:0]);
  // done still reflects the previous access during the first ACCESS cycle.
  assign done_seen = ram_done && (cnt != '0);
  assign at_limit  = (cnt == CW'(TIMEOUT - 1));

  ram_load_extend u_extend (
    .size      (ram_mas),
    .is_signed (signed_q),
    .d         (ram_rdata),
    .extended  (load_data)
  );

  always_comb begin
    next       = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) next = req_legal ? ST_SETUP : ST_RESP;
      end
      ST_SETUP:  next = ST_ACCESS;
      ST_ACCESS: if (done_seen || at_limit) next = ST_RESP;
      ST_RESP: begin
        resp_valid = 1'b1;
        next       = ST_IDLE;
      end
      default: next = ST_IDLE;
    endcase
  end

  // RAM-side registers are only loaded while ram_enable is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      write_q     <= 1'b0;
      signed_q    <= 1'b0;
      resp_err    <= 1'b0;
      resp_rdata  <= '0;
      ram_enable  <= 1'b0;
      ram_rw      <= RW_READ;
      ram_address <= '0;
      ram_mas     <= '0;
      ram_a       <= '0;
      ram_wdata   <= '0;
    end else begin
      state <= next;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            write_q    <= req_write;
            signed_q   <= req_signed;
            resp_err   <= ~req_legal;
            resp_rdata <= '0;
            if (req_legal) begin
              ram_address <= {req_addr[AW-1:2], 2'b00};
              ram_mas     <= req_size;
              ram_a       <= req_addr[1:0];
              ram_rw      <= req_write ? RW_WRITE : RW_READ;
              ram_wdata   <= req_wdata;
            end
          end
        end
        ST_SETUP: begin
          ram_enable <= 1'b1;
          cnt        <= '0;
        end
        ST_ACCESS: begin
          cnt <= cnt + CW'(1);
          if (done_seen) begin
            ram_enable <= 1'b0;
            resp_err   <= 1'b0;
            if (!write_q) resp_rdata <= load_data;
          end else if (at_limit) begin
            ram_enable <= 1'b0;
            resp_err   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Bench for ram_access_ctrl: behavioural byte-array RAM (big-endian lanes), a stub
// mode that never raises done, and a transaction-level reference model.
module tb_ram_access_ctrl;
  import ram_pkg::*;

  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [8:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic        ram_enable;
  logic        ram_rw;
  logic [8:0]  ram_address;
  logic [1:0]  ram_mas;
  logic [1:0]  ram_a;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        ram_done;

  logic        use_stub = 1'b0;
  logic        done_m = 1'b0;
  logic [31:0] ram_dout = '0;
  logic [7:0]  mem [512] = '{default: 8'h00};
  logic [7:0]  ref_mem [512] = '{default: 8'h00};

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  assign ram_rdata = ram_dout;
  assign ram_done  = use_stub ? 1'b0 : done_m;

  ram_access_ctrl #(.TIMEOUT(TO), .AW(9)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .ram_enable(ram_enable), .ram_rw(ram_rw), .ram_address(ram_address),
    .ram_mas(ram_mas), .ram_a(ram_a), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_done(ram_done)
  );

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] mem_read(input int base, input int n);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v = (v << 8) | 32'(mem[(base + i) & 511]);
    return v;
  endfunction

  // Level-sensitive RAM: acts on every enabled edge; done stays high once set (stale).
  always @(posedge clk) begin
    if (ram_enable) begin
      if (ram_rw == RW_WRITE) begin
        for (int i = 0; i < nbytes(ram_mas); i++)
          mem[(int'(ram_address) + int'(ram_a) + i) & 511] <=
            8'(ram_wdata >> (8 * (nbytes(ram_mas) - 1 - i)));
      end else begin
        ram_dout <= mem_read(int'(ram_address) + int'(ram_a), nbytes(ram_mas));
      end
      done_m <= 1'b1;
    end
  end

  typedef struct {
    logic        legal;
    logic        write;
    logic        err;
    logic [1:0]  size;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          start;
    int          due;
  } exp_t;

  exp_t q[$];

  function automatic exp_t predict(input int c);
    exp_t e;
    int a;
    int n;
    logic [31:0] v;
    a = int'(req_addr);
    n = nbytes(req_size);
    e.write = req_write;
    e.size  = req_size;
    e.addr  = req_addr;
    e.wdata = req_wdata;
    e.legal = (req_size != 2'b11) && (a % n == 0);
    e.start = c + 2;
    e.due   = !e.legal ? c + 1 : c + 2 + (use_stub ? int'(TO) : 2);
    e.err   = !e.legal || use_stub;
    e.rdata = '0;
    if (e.legal && !use_stub) begin
      if (req_write) begin
        for (int i = 0; i < n; i++) ref_mem[a + i] = 8'(req_wdata >> (8 * (n - 1 - i)));
      end else begin
        v = '0;
        for (int i = 0; i < n; i++) v = v * 256 + 32'(ref_mem[a + i]);
        if (req_signed && n < 4 && v >= 32'(1 << (8 * n - 1))) v = v - 32'(1 << (8 * n));
        e.rdata = v;
      end
    end
    return e;
  endfunction

  // Per-cycle compare against the transaction model, sampled on the falling edge.
  initial begin
    exp_t e;
    int   low_run;
    logic prev_en;
    logic seen_en;
    low_run = 0;
    prev_en = 1'b0;
    seen_en = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        q.delete();
        seen_en = 1'b0;
        prev_en = 1'b0;
      end else begin
        if (ram_enable) begin
          if (!prev_en && seen_en) chk1("enable_gap_ge2", low_run >= 2, 1'b1);
          seen_en = 1'b1;
          low_run = 0;
        end else begin
          low_run++;
        end
        prev_en = ram_enable;
        if (q.size() == 0) begin
          chk1("idle_req_ready", req_ready, 1'b1);
          chk1("idle_ram_enable", ram_enable, 1'b0);
          chk1("idle_resp_valid", resp_valid, 1'b0);
        end else begin
          e = q[0];
          chk1("busy_req_ready", req_ready, 1'b0);
          chk1("resp_valid_timing", resp_valid, cyc == e.due);
          chk1("ram_enable_window", ram_enable, e.legal && cyc >= e.start && cyc < e.due);
          if (ram_enable) begin
            chk32("ram_address", 32'(ram_address), 32'({e.addr[8:2], 2'b00}));
            chk32("ram_mas", 32'(ram_mas), 32'(e.size));
            chk32("ram_a", 32'(ram_a), 32'(e.addr[1:0]));
            chk1("ram_rw", ram_rw, !e.write);
            if (e.write) chk32("ram_wdata", ram_wdata, e.wdata);
          end
          if (resp_valid || cyc >= e.due) begin
            chk1("model_resp_err", resp_err, e.err);
            chk32("model_resp_rdata", resp_rdata, e.rdata);
            void'(q.pop_front());
          end
        end
        if (req_valid && req_ready) q.push_back(predict(cyc));
      end
    end
  end

  task automatic drive(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [8:0] ad, input logic [31:0] wd);
    req_valid  = 1'b1;
    req_write  = w;
    req_size   = sz;
    req_signed = sg;
    req_addr   = ad;
    req_wdata  = wd;
  endtask

  task automatic wait_accept(input string name);
    bit got;
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (req_ready) got = 1;
    end
    chk1({name, "_accepted"}, got, 1'b1);
  endtask

  task automatic do_req(input string name, input logic w, input logic [1:0] sz,
                        input logic sg, input logic [8:0] ad, input logic [31:0] wd,
                        input logic exp_err, input logic [31:0] exp_rd, input int exp_lat);
    bit got;
    int lat;
    @(posedge clk); #1;
    drive(w, sz, sg, ad, wd);
    wait_accept(name);
    @(posedge clk); #1;
    req_valid = 1'b0;
    got = 0;
    lat = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        got = 1;
        lat = i + 1;
      end
    end
    chk1({name, "_resp_seen"}, got, 1'b1);
    if (got) begin
      chk1({name, "_err"}, resp_err, exp_err);
      chk32({name, "_rdata"}, resp_rdata, exp_rd);
      chk32({name, "_latency"}, 32'(lat), 32'(exp_lat));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    bit saw_a;
    int i_resp;
    int i_acc;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk1("rst_req_ready", req_ready, 1'b1);
    chk1("rst_resp_valid", resp_valid, 1'b0);
    chk1("rst_resp_err", resp_err, 1'b0);
    chk32("rst_resp_rdata", resp_rdata, 32'h0);
    chk1("rst_ram_enable", ram_enable, 1'b0);
    chk1("rst_ram_rw", ram_rw, 1'b1);
    chk32("rst_ram_address", 32'(ram_address), 32'h0);
    chk32("rst_ram_mas", 32'(ram_mas), 32'h0);
    chk32("rst_ram_a", 32'(ram_a), 32'h0);
    chk32("rst_ram_wdata", ram_wdata, 32'h0);

    do_req("st_word_010",  1'b1, 2'b10, 1'b0, 9'h010, 32'hDEADBEEF, 1'b0, 32'h0, 4);
    do_req("ld_word_010",  1'b0, 2'b10, 1'b0, 9'h010, 32'h0,        1'b0, 32'hDEADBEEF, 4);
    do_req("st_byte_013",  1'b1, 2'b00, 1'b0, 9'h013, 32'h00000080, 1'b0, 32'h0, 4);
    do_req("ld_sbyte_013", 1'b0, 2'b00, 1'b1, 9'h013, 32'h0,        1'b0, 32'hFFFFFF80, 4);
    do_req("ld_ubyte_013", 1'b0, 2'b00, 1'b0, 9'h013, 32'h0,        1'b0, 32'h00000080, 4);
    do_req("st_word_010b", 1'b1, 2'b10, 1'b0, 9'h010, 32'h1234F00D, 1'b0, 32'h0, 4);
    do_req("ld_shalf_012", 1'b0, 2'b01, 1'b1, 9'h012, 32'h0,        1'b0, 32'hFFFFF00D, 4);
    do_req("ld_uhalf_010", 1'b0, 2'b01, 1'b0, 9'h010, 32'h0,        1'b0, 32'h00001234, 4);
    do_req("ld_word_011",  1'b0, 2'b10, 1'b0, 9'h011, 32'h0,        1'b1, 32'h0, 1);
    do_req("ld_half_013",  1'b0, 2'b01, 1'b0, 9'h013, 32'h0,        1'b1, 32'h0, 1);
    do_req("st_mas11",     1'b1, 2'b11, 1'b0, 9'h010, 32'h55555555, 1'b1, 32'h0, 1);
    do_req("st_half_1fe",  1'b1, 2'b01, 1'b0, 9'h1FE, 32'h0000ABCD, 1'b0, 32'h0, 4);
    do_req("ld_word_1fc",  1'b0, 2'b10, 1'b0, 9'h1FC, 32'h0,        1'b0, 32'h0000ABCD, 4);

    use_stub = 1'b1;
    do_req("ld_timeout",   1'b0, 2'b10, 1'b0, 9'h010, 32'h0,        1'b1, 32'h0, 2 + int'(TO));
    use_stub = 1'b0;

    // Reset while the RAM is enabled.
    @(posedge clk); #1;
    drive(1'b0, 2'b00, 1'b0, 9'h010, 32'h0);
    wait_accept("abort");
    @(posedge clk); #1;
    req_valid = 1'b0;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (ram_enable) got = 1;
    end
    chk1("abort_enable_seen", got, 1'b1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk1("abort_ram_enable", ram_enable, 1'b0);
    chk1("abort_req_ready", req_ready, 1'b1);
    chk1("abort_resp_valid", resp_valid, 1'b0);
    got = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (resp_valid) got = 1;
    end
    chk1("abort_no_resp", got, 1'b0);

    // Back-to-back: second request held valid through the first response.
    @(posedge clk); #1;
    drive(1'b0, 2'b10, 1'b0, 9'h010, 32'h0);
    wait_accept("b2b_a");
    @(posedge clk); #1;
    drive(1'b1, 2'b00, 1'b0, 9'h1FF, 32'h0000005A);
    got = 0;
    saw_a = 0;
    i_resp = 0;
    i_acc = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        saw_a = 1;
        i_resp = i;
        chk32("b2b_a_rdata", resp_rdata, 32'h1234F00D);
      end
      if (req_ready) begin
        got = 1;
        i_acc = i;
      end
    end
    chk1("b2b_a_resp_seen", saw_a, 1'b1);
    chk1("b2b_b_accepted", got, 1'b1);
    chk32("b2b_b_accept_after_resp", 32'(i_acc - i_resp), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (resp_valid) got = 1;
    end
    chk1("b2b_b_resp_seen", got, 1'b1);
    chk1("b2b_b_err", resp_err, 1'b0);
    do_req("ld_ubyte_1ff", 1'b0, 2'b00, 1'b0, 9'h1FF, 32'h0, 1'b0, 32'h0000005A, 4);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
